instr_fetch_queue: RTL and testbench

- Small show-ahead instruction FIFO directly downstream of the PC/instruction-ROM fetch stage; feeds the decode stage.
- Captures each fetched instruction word with its PC, and decouples fetch from decode stalls with a valid/ready handshake on both sides.
- A flush input discards all queued entries on a taken branch or jump so that no wrong-path instruction reaches decode.

---
 rtl/instr_fetch_queue.sv | 104 ++++++++++
 tb/tb_instr_fetch_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Show-ahead instruction FIFO between the fetch stage and decode.
// Each entry holds one fetched instruction word and its PC. The head entry is
// always visible on out_*; when the queue is empty the head reads as a NOP at
// PC 0 so decode never sees a stale word. A flush drops every queued entry
// so wrong-path instructions after a taken branch/jump never reach decode.
module instr_fetch_queue #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDRESS_WIDTH = 8,
    parameter int                    DEPTH         = 4,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD      = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_instr,
    input  logic [ADDRESS_WIDTH-1:0]   in_pc,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_instr,
    output logic [ADDRESS_WIDTH-1:0]   out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_EMPTY  = '0;

    // Pointer wrap relies on the natural modulo of a power-of-two depth.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_fetch_queue: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_WIDTH-1:0]    instr_mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] occ;

    logic push;
    logic pop;

    // Handshake qualifiers; both depend only on registered occupancy, so
    // in_ready has no combinational path from out_ready.
    always_comb begin
        in_ready  = (occ != CNT_FULL);
        out_valid = (occ != CNT_EMPTY);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Storage write: data payload only, no reset needed; a flush discards the
    // coincident push so it is not written either.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    // Pointer and occupancy update; flush outranks push/pop, reset outranks all.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   occ <= occ + CNT_ONE;
                2'b01:   occ <= occ - CNT_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // Head presentation: stored entry when valid, otherwise a NOP at PC 0.
    always_comb begin
        count = occ;
        if (out_valid) begin
            out_instr = instr_mem[rd_ptr];
            out_pc    = pc_mem[rd_ptr];
        end else begin
            out_instr = NOP_WORD;
            out_pc    = '0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised and directed bench for instr_fetch_queue with a queue-based
// reference model and a decoupled output monitor.
module tb_instr_fetch_queue;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam logic [DW-1:0] NOP = 32'h00000013;

    typedef struct {
        logic [DW-1:0] instr;
        logic [AW-1:0] pc;
    } ent_t;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic [DW-1:0]       in_instr;
    logic [AW-1:0]       in_pc;
    logic                in_ready;
    logic                flush;
    logic                out_valid;
    logic [DW-1:0]       out_instr;
    logic [AW-1:0]       out_pc;
    logic                out_ready;
    logic [$clog2(DEPTH):0] count;

    ent_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    instr_fetch_queue #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .flush(flush),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare visible queue state against the model contents.
    task automatic check_state(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, ".count"},     32'(count),     32'(n));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(n != DEPTH));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
        if (n == 0) begin
            chk({tag, ".nop_instr"}, out_instr, NOP);
            chk({tag, ".nop_pc"},    32'(out_pc), 32'd0);
        end else begin
            chk({tag, ".head_instr"}, out_instr, exp_q[0].instr);
            chk({tag, ".head_pc"},    32'(out_pc), 32'(exp_q[0].pc));
        end
    endtask

    // One clock of stimulus: check, drive, predict, advance to just after the edge.
    task automatic cycle(input string tag, input logic v, input logic [DW-1:0] ins,
                         input logic [AW-1:0] p, input logic rdy, input logic fl);
        int  n;
        ent_t e;
        check_state(tag);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = p;
        out_ready = rdy;
        flush     = fl;
        n = exp_q.size();
        if (fl) begin
            exp_q.delete();
        end else if (v && n != DEPTH) begin
            e.instr = ins;
            e.pc    = p;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic rdy);
        cycle(tag, 1'b0, '0, '0, rdy, 1'b0);
    endtask

    // Output monitor: every accepted head must be the oldest expected entry.
    always @(negedge clk) begin
        ent_t e;
        if (rst && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL mon.unexpected: got pc %h instr %h expected no entry", out_pc, out_instr);
            end else begin
                e = exp_q.pop_front();
                chk("mon.instr", out_instr, e.instr);
                chk("mon.pc",    32'(out_pc), 32'(e.pc));
            end
        end
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset held low, checked before any clock edge
        #2;
        check_state("reset");
        #5;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full, fifth push ignored
        for (int i = 0; i < DEPTH; i++)
            cycle("fill", 1'b1, 32'hA000_0000 + 32'(i), AW'(4 * i), 1'b0, 1'b0);
        cycle("full", 1'b1, 32'hA000_0004, AW'(16), 1'b0, 1'b0);
        idle("full_hold", 1'b0);

        // Drain in order
        for (int i = 0; i < DEPTH; i++) idle("drain", 1'b1);
        idle("drained", 1'b0);

        // Full with simultaneous pop: pop only, push accepted next cycle
        for (int i = 0; i < DEPTH; i++)
            cycle("refill", 1'b1, 32'hB000_0000 + 32'(i), AW'(64 + 4 * i), 1'b0, 1'b0);
        cycle("fullpop", 1'b1, 32'hB000_0010, AW'(100), 1'b1, 1'b0);
        cycle("afterpop", 1'b1, 32'hB000_0010, AW'(100), 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) idle("drain2", 1'b1);

        // Streaming with pointer wrap
        for (int i = 0; i < 12; i++)
            cycle("stream", 1'b1, 32'hC000_0000 + 32'(i), AW'(4 * i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle("stream_tail", 1'b1);

        // Flush with coincident push and pop
        for (int i = 0; i < 3; i++)
            cycle("preflush", 1'b1, 32'hD000_0000 + 32'(i), AW'(128 + 4 * i), 1'b0, 1'b0);
        cycle("flush", 1'b1, 32'hDEAD_BEEF, AW'(200), 1'b1, 1'b1);
        idle("postflush", 1'b0);
        cycle("pushpost", 1'b1, 32'hD000_0010, AW'(204), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) idle("drain3", 1'b1);

        // Asynchronous reset mid-operation
        cycle("prereset", 1'b1, 32'hE000_0000, AW'(8), 1'b0, 1'b0);
        cycle("prereset", 1'b1, 32'hE000_0001, AW'(12), 1'b0, 1'b0);
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_state("midreset");
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 3) != 0), 32'($urandom), AW'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end

        for (int i = 0; i < DEPTH + 1; i++) idle("final_drain", 1'b1);
        check_state("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
